// File: rtl/interrupt_ack_control.sv
// In-service tracking and two-pulse INTA acknowledge for an 8-line interrupt controller.
// Owns the ISR, drives INT to the CPU and returns the vector byte on the second INTA.
module interrupt_ack_control #(
  parameter int NUM_IR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_pending,
  input  logic [2:0] highest_num,
  input  logic       inta_pulse,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic {IDLE = 1'b0, WAIT2 = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [2:0] level_reg, level_next;
  logic       spurious_reg, spurious_next;
  logic       int_next;
  logic [7:0] isr_next;
  logic [7:0] clear_irr_next;
  logic [7:0] data_out_next;
  logic       data_out_en_next;

  logic [3:0] lowest_isr;
  logic       req_ok;
  logic [7:0] eoi_clear;
  logic [7:0] isr_after_eoi;

  // Lowest set ISR bit is the highest-priority level in service; 8 means none.
  always_comb begin
    lowest_isr = 4'd8;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (isr[i]) lowest_isr = 4'(i);
    end
  end

  assign req_ok = (irq_pending != 8'h00) && ({1'b0, highest_num} < lowest_isr);

  // EOI target is always chosen from the pre-update ISR.
  always_comb begin
    eoi_clear = 8'h00;
    if (eoi_valid) begin
      if (eoi_specific)
        eoi_clear[eoi_level] = 1'b1;
      else if (lowest_isr != 4'd8)
        eoi_clear[lowest_isr[2:0]] = 1'b1;
    end
  end

  assign isr_after_eoi = isr & ~eoi_clear;

  always_comb begin
    state_next       = state_reg;
    level_next       = level_reg;
    spurious_next    = spurious_reg;
    int_next         = 1'b0;
    isr_next         = isr_after_eoi;
    clear_irr_next   = 8'h00;
    data_out_next    = data_out;
    data_out_en_next = 1'b0;

    case (state_reg)
      IDLE: begin
        int_next = req_ok;
        if (inta_pulse) begin
          int_next   = 1'b0;
          state_next = WAIT2;
          if (req_ok) begin
            level_next                = highest_num;
            isr_next[highest_num]     = 1'b1;
            clear_irr_next[highest_num] = 1'b1;
          end else begin
            level_next    = 3'd7;
            spurious_next = 1'b1;
          end
        end
      end
      WAIT2: begin
        if (inta_pulse) begin
          data_out_next    = {vector_base, level_reg};
          data_out_en_next = 1'b1;
          if (aeoi && !spurious_reg) isr_next[level_reg] = 1'b0;
          spurious_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      level_reg    <= 3'd0;
      spurious_reg <= 1'b0;
      int_out      <= 1'b0;
      isr          <= 8'h00;
      clear_irr    <= 8'h00;
      data_out     <= 8'h00;
      data_out_en  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      level_reg    <= level_next;
      spurious_reg <= spurious_next;
      int_out      <= int_next;
      isr          <= isr_next;
      clear_irr    <= clear_irr_next;
      data_out     <= data_out_next;
      data_out_en  <= data_out_en_next;
    end
  end

endmodule

// File: tb/tb_interrupt_ack_control.sv
// Directed-vector bench for interrupt_ack_control with hand-computed expectations.
module tb_interrupt_ack_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_pending;
  logic [2:0] highest_num;
  logic       inta_pulse;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  int checks = 0;
  int errors = 0;

  interrupt_ack_control #(.NUM_IR(8)) dut (
    .clk(clk), .reset(reset), .irq_pending(irq_pending), .highest_num(highest_num),
    .inta_pulse(inta_pulse), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .aeoi(aeoi), .vector_base(vector_base),
    .int_out(int_out), .isr(isr), .clear_irr(clear_irr),
    .data_out(data_out), .data_out_en(data_out_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  // Inputs change #1 after the edge; outputs are then sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] p, input logic [2:0] n);
    irq_pending = p;
    highest_num = n;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_pending = 8'h00; highest_num = 3'd7; inta_pulse = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; aeoi = 1'b0;
    vector_base = 5'b01000;
    tick(); tick();
    reset = 1'b0;
    check("rst_isr", isr, 8'h00);
    check("rst_int", {7'd0, int_out}, 8'h00);
    check("rst_clr", clear_irr, 8'h00);
    check("rst_dout", data_out, 8'h00);
    check("rst_den", {7'd0, data_out_en}, 8'h00);

    // Basic acknowledge of IR3
    req(8'h08, 3'd3);
    tick();
    check("basic_int", {7'd0, int_out}, 8'h01);
    inta();
    req(8'h00, 3'd7);
    check("basic_isr1", isr, 8'h08);
    check("basic_clr1", clear_irr, 8'h08);
    check("basic_int1", {7'd0, int_out}, 8'h00);
    tick();
    check("basic_clr_gone", clear_irr, 8'h00);
    check("basic_den_wait", {7'd0, data_out_en}, 8'h00);
    inta();
    check("basic_dout", data_out, 8'h43);
    check("basic_den", {7'd0, data_out_en}, 8'h01);
    check("basic_isr2", isr, 8'h08);
    tick();
    check("basic_den_off", {7'd0, data_out_en}, 8'h00);
    check("basic_dout_hold", data_out, 8'h43);

    // Lower priority blocked, higher priority nests
    req(8'h20, 3'd5);
    tick(); tick();
    check("block_int", {7'd0, int_out}, 8'h00);
    req(8'h02, 3'd1);
    tick();
    check("nest_int", {7'd0, int_out}, 8'h01);
    inta();
    req(8'h00, 3'd7);
    check("nest_isr", isr, 8'h0A);
    check("nest_clr", clear_irr, 8'h02);
    inta();
    check("nest_dout", data_out, 8'h41);

    // EOI: non-specific clears IR1, specific clears IR3
    eoi(1'b0, 3'd0);
    check("nseoi_isr", isr, 8'h08);
    eoi(1'b1, 3'd3);
    check("seoi_isr", isr, 8'h00);
    eoi(1'b0, 3'd0);
    check("nseoi_empty", isr, 8'h00);

    // Auto-EOI on IR7
    aeoi = 1'b1;
    req(8'h80, 3'd7);
    tick();
    check("aeoi_int", {7'd0, int_out}, 8'h01);
    inta();
    req(8'h00, 3'd7);
    check("aeoi_isr1", isr, 8'h80);
    inta();
    check("aeoi_isr2", isr, 8'h00);
    check("aeoi_den", {7'd0, data_out_en}, 8'h01);
    check("aeoi_dout", data_out, 8'h47);
    aeoi = 1'b0;

    // Spurious acknowledge with IR3 in service
    req(8'h08, 3'd3);
    tick();
    inta();
    req(8'h00, 3'd7);
    inta();
    check("pre_spur_isr", isr, 8'h08);
    tick();
    inta();
    check("spur_isr1", isr, 8'h08);
    check("spur_clr", clear_irr, 8'h00);
    check("spur_int", {7'd0, int_out}, 8'h00);
    inta();
    check("spur_dout", data_out, 8'h47);
    check("spur_isr2", isr, 8'h08);

    // Same-edge: non-specific EOI on IR3 with INTA1 setting IR1
    req(8'h02, 3'd1);
    tick();
    eoi_valid = 1'b1; eoi_specific = 1'b0;
    inta();
    eoi_valid = 1'b0;
    req(8'h00, 3'd7);
    check("conflict_isr", isr, 8'h02);
    inta();
    check("conflict_dout", data_out, 8'h41);
    eoi(1'b1, 3'd1);
    check("conflict_clear", isr, 8'h00);

    // Reset while waiting for INTA2; next INTA is a fresh first pulse
    req(8'h04, 3'd2);
    tick();
    inta();
    check("w2_isr", isr, 8'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req(8'h00, 3'd7);
    check("w2rst_isr", isr, 8'h00);
    check("w2rst_int", {7'd0, int_out}, 8'h00);
    inta();
    check("w2rst_inta1_den", {7'd0, data_out_en}, 8'h00);
    inta();
    check("w2rst_inta2_den", {7'd0, data_out_en}, 8'h01);
    check("w2rst_dout", data_out, 8'h47);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
